// File: rtl/tdm_demux9_4bits_if.sv
// tdm_demux9_4bits_if: time-division stream bus (din, din_valid, sof); master drives, slave receives
interface tdm_demux9_4bits_if #(parameter int W = 4);
    logic [W-1:0] din;
    logic         din_valid;
    logic         sof;
    modport master (output din, din_valid, sof);
    modport slave  (input din, din_valid, sof);
endinterface

// File: rtl/tdm_demux9_4bits.sv
// tdm_demux9_4bits: rebuilds nine W-bit channels from a TDM stream (s: din/din_valid/sof; q0..q8 published frame; slot next write index; locked in RUN; frame_done/sync_err one-cycle pulses)
module tdm_demux9_4bits #(
    parameter int W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tdm_demux9_4bits_if.slave      s,
    output logic [W-1:0]           q0,
    output logic [W-1:0]           q1,
    output logic [W-1:0]           q2,
    output logic [W-1:0]           q3,
    output logic [W-1:0]           q4,
    output logic [W-1:0]           q5,
    output logic [W-1:0]           q6,
    output logic [W-1:0]           q7,
    output logic [W-1:0]           q8,
    output logic [3:0]             slot,
    output logic                   locked,
    output logic                   frame_done,
    output logic                   sync_err
);
    typedef enum logic {HUNT, RUN} state_t;
    state_t       state, state_d;
    logic [W-1:0] shadow [0:8];
    logic [W-1:0] qr [0:8];
    logic [3:0]   slot_d, widx;
    logic         wr, pub, fd_d, se_d;
    assign {q8, q7, q6, q5, q4, q3, q2, q1, q0} = {qr[8], qr[7], qr[6], qr[5], qr[4], qr[3], qr[2], qr[1], qr[0]};
    assign locked = state == RUN;
    // any sof beat restarts the frame at slot 0
    assign widx = s.sof ? 4'd0 : slot;
    always_comb begin
        state_d = state;
        slot_d  = slot;
        wr      = 1'b0;
        pub     = 1'b0;
        fd_d    = 1'b0;
        se_d    = 1'b0;
        if (s.din_valid) begin
            if (state == HUNT) begin
                if (s.sof) begin
                    wr      = 1'b1;
                    slot_d  = 4'd1;
                    state_d = RUN;
                end
            end else if (s.sof) begin
                // sof mid-frame abandons the partial frame
                wr     = 1'b1;
                slot_d = 4'd1;
                se_d   = slot != 4'd0;
            end else if (slot == 4'd0) begin
                se_d    = 1'b1;
                state_d = HUNT;
            end else begin
                wr     = 1'b1;
                pub    = slot == 4'd8;
                fd_d   = pub;
                slot_d = pub ? 4'd0 : slot + 4'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= HUNT;
            slot       <= 4'd0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                shadow[k] <= '1;
                qr[k]     <= '1;
            end
        end else begin
            state      <= state_d;
            slot       <= slot_d;
            frame_done <= fd_d;
            sync_err   <= se_d;
            if (wr) shadow[widx] <= s.din;
            // slot 8 comes straight from din so the whole frame lands on one edge
            if (pub) begin
                for (int k = 0; k < 8; k++) qr[k] <= shadow[k];
                qr[8] <= s.din;
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux9_4bits.sv
// tb_tdm_demux9_4bits: scoreboard bench with directed frames and random framing against a queue-based frame model
module tb_tdm_demux9_4bits;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  q0, q1, q2, q3, q4, q5, q6, q7, q8, slot;
    logic        locked, frame_done, sync_err;
    tdm_demux9_4bits_if #(.W(4)) bus ();
    tdm_demux9_4bits #(.W(4)) dut (
        .clk(clk), .rst_n(rst_n), .s(bus.slave),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7), .q8(q8),
        .slot(slot), .locked(locked), .frame_done(frame_done), .sync_err(sync_err)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        bit          err;
        logic [35:0] q;
    } ev_t;
    ev_t        exq[$];
    ev_t        e;
    logic [3:0] cur[$];
    bit         mlocked;
    logic [35:0] pub;
    int         n_cmp = 0;
    int         n_fail = 0;
    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic logic [35:0] qall();
        return {q8, q7, q6, q5, q4, q3, q2, q1, q0};
    endfunction
    task automatic model(input bit s, input logic [3:0] d);
        logic [35:0] v;
        if (!mlocked) begin
            if (s) begin mlocked = 1; cur = {d}; end
        end else if (s) begin
            if (cur.size() != 0) exq.push_back('{err: 1, q: '0});
            cur = {d};
        end else if (cur.size() == 0) begin
            exq.push_back('{err: 1, q: '0});
            mlocked = 0;
        end else begin
            cur.push_back(d);
            if (cur.size() == 9) begin
                v = '0;
                for (int i = 0; i < 9; i++) v[i*4 +: 4] = cur[i];
                exq.push_back('{err: 0, q: v});
                cur = {};
            end
        end
    endtask
    task automatic beat(input bit s, input logic [3:0] d);
        bus.din_valid = 1'b1;
        bus.sof = s;
        bus.din = d;
        @(posedge clk);
        model(s, d);
        #1;
        bus.din_valid = 1'b0;
        bus.sof = 1'b0;
        bus.din = 4'($urandom);
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        exq = {};
        cur = {};
        mlocked = 0;
        pub = '1;
        #1 rst_n = 1'b1;
    endtask
    task automatic frame(input logic [3:0] first, input int step, input int n);
        for (int i = 0; i < n; i++) beat(i == 0, 4'(int'(first) + i * step));
    endtask
    task automatic chk_q(input string nm, input logic [35:0] exp);
        @(negedge clk);
        chk(nm, qall(), exp);
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            chk("pulse_overlap", {35'd0, frame_done & sync_err}, 36'd0);
            if (frame_done || sync_err) begin
                if (exq.size() == 0) chk("unexpected_pulse", {34'd0, frame_done, sync_err}, 36'd0);
                else begin
                    e = exq.pop_front();
                    chk("pulse_kind", {34'd0, frame_done, sync_err}, e.err ? 36'd1 : 36'd2);
                    if (!e.err) pub = e.q;
                end
            end else if (exq.size() != 0) begin
                e = exq.pop_front();
                chk("missing_pulse", 36'd0, e.err ? 36'd1 : 36'd2);
                if (!e.err) pub = e.q;
            end
            chk("q", qall(), pub);
            chk("slot", {32'd0, slot}, 36'(cur.size()));
            chk("locked", {35'd0, locked}, {35'd0, mlocked});
        end
    end
    initial begin
        bus.din_valid = 1'b0;
        bus.sof = 1'b0;
        bus.din = 4'd0;
        pub = '1;
        do_reset();
        idle(3);
        chk_q("reset_q", 36'hFFFFFFFFF);
        chk("reset_locked", {35'd0, locked}, 36'd0);
        frame(4'd1, 1, 9);
        chk_q("clean_q", 36'h987654321);
        chk("clean_locked", {35'd0, locked}, 36'd1);
        for (int i = 0; i < 9; i++) begin
            if (i == 4) idle(3);
            beat(i == 0, 4'(i + 1));
        end
        chk_q("gapped_q", 36'h987654321);
        frame(4'hA, 1, 5);
        frame(4'd3, 1, 9);
        chk_q("early_sof_q", 36'hBA9876543);
        beat(1'b0, 4'd7);
        beat(1'b0, 4'd2);
        beat(1'b0, 4'd5);
        chk_q("hunt_q_hold", 36'hBA9876543);
        chk("hunt_locked", {35'd0, locked}, 36'd0);
        frame(4'd5, 1, 9);
        frame(4'd2, 1, 6);
        do_reset();
        chk_q("reset_mid_q", 36'hFFFFFFFFF);
        chk("reset_mid_locked", {35'd0, locked}, 36'd0);
        frame(4'd9, -1, 9);
        chk_q("fresh_q", 36'h123456789);
        repeat (80) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 9;
            if ($urandom_range(0, 7) == 0) beat(1'b0, 4'($urandom));
            if ($urandom_range(0, 29) == 0) do_reset();
            beat(1'b1, 4'($urandom));
            for (int i = 1; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                beat(1'b0, 4'($urandom));
            end
        end
        idle(3);
        chk("queue_empty", 36'(exq.size()), 36'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/tdm_demux9_4bits.md
Name: tdm_demux9_4bits

Overview:
- Receive-side counterpart of the 9-way, 4-bit selector: rebuilds nine parallel 4-bit channels from a time-division stream.
- The stream carries one nibble per valid beat, in slot order 0..8, with slot 0 flagged by sof.
- Each slot is captured into a shadow bank. On the slot-8 beat the whole bank is published to the registered outputs Q0..Q8 in one edge, so a consumer never sees a torn frame.
- Frame-sync errors are detected; the block re-locks on the next sof.

Parameters:
- W, 4, width of each channel and of din.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- din  input  W  stream data for the current slot.
- din_valid  input  1  din/sof are meaningful this cycle (one beat).
- sof  input  1  start of frame; qualifies a beat as slot 0. Ignored when din_valid=0.
- Q0..Q8  output  W each  published channel values (nine separate ports).
- slot  output  4  slot index the next valid beat is written to (0..8).
- locked  output  1  1 = in RUN, tracking a frame.
- frame_done  output  1  one-cycle pulse; Q0..Q8 updated on the same edge.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Q0..Q8 = all ones ({W{1'b1}}); shadow bank = all ones.
  - slot=0, locked=0, frame_done=0, sync_err=0.
  - Reset mid-frame discards the partial frame; Q keeps no old data, it is forced to all ones.
- States: HUNT (locked=0), RUN (locked=1).
- HUNT:
  - A valid beat with sof=0 is dropped; no pulse is generated.
  - A valid beat with sof=1 writes shadow[0]=din, sets slot=1 and moves to RUN.
- RUN, on a valid beat with sof=0 and slot in 1..7:
  - shadow[slot]=din, slot+=1.
- RUN, on a valid beat with sof=0 and slot==8:
  - shadow[8]=din.
  - Qk=shadow[k] for k=0..7 and Q8=din, all on the same edge.
  - frame_done=1 for that cycle; slot wraps to 0; remain in RUN.
- RUN, slot==0 (frame just completed):
  - A valid beat with sof=1 writes shadow[0], sets slot=1 and continues in RUN.
  - A valid beat with sof=0 is a violation: sync_err=1, the beat is dropped, slot=0, go to HUNT.
- RUN, slot in 1..8, valid beat with sof=1 (early sof):
  - sync_err=1.
  - The partial frame is abandoned; shadow entries written so far are not published.
  - The beat is taken as a new slot 0: shadow[0]=din, slot=1, stay in RUN.
  - frame_done is not asserted.
- din_valid=0: no state change, no pulse. Gaps between beats of any length are allowed.
- Q0..Q8 change only on frame_done edges (or reset). A frame takes at least 9 cycles, so frame_done and sync_err never assert in the same cycle.
- Latency: Q and frame_done become visible in the cycle after the slot-8 beat is sampled.
- slot never takes values 9..15. Channels map one-to-one by slot index, matching selector codes 0000..1000.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 → Q0..Q8=4'hF, slot=0, locked=0, no pulses.
- Clean frame: 9 back-to-back beats, sof on the first, din=1,2,…,9 → one frame_done pulse after the 9th beat; Q0=1 … Q8=9; locked=1; slot back to 0.
- Gapped frame: same data with din_valid low for 3 cycles between beats 4 and 5 → identical Q result; frame_done exactly once; sync_err never asserted.
- Early sof: 5 beats of frame A (sof, din=A..E), then sof beat din=3 followed by 8 beats din=4..B → one sync_err pulse at the second sof; Q unchanged until the following frame_done; then Q0..Q8=3,4,…,B.
- Missing sof: after a good frame, a beat with sof=0 and din=7 → sync_err pulse, locked=0. Subsequent non-sof beats are dropped with no pulse, and Q holds the previous frame. The next sof re-locks.
- Reset mid-frame: rst_n=0 after 6 beats of a second frame → Q=4'hF all, locked=0. A fresh frame din=9..1 then yields Q0=9 … Q8=1.
